helios_stream_decoder: RTL and testbench



---
 rtl/helios_stream_pkg.sv | 31 +++
 rtl/single_FPGA_decoding_graph.sv | 81 ++++++++
 rtl/syndrome_layer_buffer.sv | 42 ++++
 rtl/unified_controller.sv | 46 ++++
 rtl/helios_stream_decoder.sv | 150 +++++++++++++++
 tb/tb_helios_stream_decoder.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/helios_stream_pkg.sv
// Shared types and constants for the streaming Helios decoder: top FSM states,
// controller stage codes and lattice address sizing helpers.
package helios_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_IDLE = 2'd0;
    localparam logic [1:0] CTRL_RUN  = 2'd1;
    localparam logic [1:0] CTRL_DONE = 2'd2;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of one coordinate (x, z or round); never below one bit.
    function automatic int coord_width(input int x, input int z, input int r);
        int w;
        w = $clog2(max_of(max_of(x, z), r));
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int addr_width(input int x, input int z, input int r);
        return 3 * coord_width(x, z, r);
    endfunction

endpackage

// File: rtl/single_FPGA_decoding_graph.sv
// Lattice of processing units; each defect PU adopts the smallest root among
// itself and its defect neighbours once per step until clusters settle.
module single_FPGA_decoding_graph
    import helios_stream_pkg::*;
#(
    parameter int CODE_DISTANCE_X    = 3,
    parameter int CODE_DISTANCE_Z    = 2,
    parameter int MEASUREMENT_ROUNDS = 3,
    parameter int WEIGHT_X           = 2,
    parameter int WEIGHT_Z           = 2,
    parameter int WEIGHT_M           = 2,
    parameter int ADDRESS_WIDTH      = 6,
    localparam int LAYER_PUS         = CODE_DISTANCE_X * CODE_DISTANCE_Z,
    localparam int PU_COUNT          = LAYER_PUS * MEASUREMENT_ROUNDS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_round_start,
    input  logic                              step,
    input  logic [PU_COUNT-1:0]               measurements,
    output logic                              changed,
    output logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int CW = ADDRESS_WIDTH / 3;
    // A zero-weight edge class is treated as absent from the graph.
    localparam bit EN_X = (WEIGHT_X != 0);
    localparam bit EN_Z = (WEIGHT_Z != 0);
    localparam bit EN_M = (WEIGHT_M != 0);

    logic [PU_COUNT-1:0]    defect;
    logic [AW*PU_COUNT-1:0] own_roots;
    logic [AW*PU_COUNT-1:0] next_roots;

    for (genvar p = 0; p < PU_COUNT; p++) begin : g_pu
        localparam int PX  = p % CODE_DISTANCE_X;
        localparam int PZ  = (p % LAYER_PUS) / CODE_DISTANCE_X;
        localparam int PR  = p / LAYER_PUS;
        // Missing neighbours at the lattice edge point back at the PU itself.
        localparam int NXM = (PX > 0) ? p - 1 : p;
        localparam int NXP = (PX < CODE_DISTANCE_X - 1) ? p + 1 : p;
        localparam int NZM = (PZ > 0) ? p - CODE_DISTANCE_X : p;
        localparam int NZP = (PZ < CODE_DISTANCE_Z - 1) ? p + CODE_DISTANCE_X : p;
        localparam int NRM = (PR > 0) ? p - LAYER_PUS : p;
        localparam int NRP = (PR < MEASUREMENT_ROUNDS - 1) ? p + LAYER_PUS : p;

        logic [AW-1:0] best;

        assign own_roots[p*AW +: AW] = AW'((PR << (2 * CW)) | (PZ << CW) | PX);

        always_comb begin
            best = roots[p*AW +: AW];
            if (defect[p]) begin
                if (EN_X && defect[NXM] && roots[NXM*AW +: AW] < best) best = roots[NXM*AW +: AW];
                if (EN_X && defect[NXP] && roots[NXP*AW +: AW] < best) best = roots[NXP*AW +: AW];
                if (EN_Z && defect[NZM] && roots[NZM*AW +: AW] < best) best = roots[NZM*AW +: AW];
                if (EN_Z && defect[NZP] && roots[NZP*AW +: AW] < best) best = roots[NZP*AW +: AW];
                if (EN_M && defect[NRM] && roots[NRM*AW +: AW] < best) best = roots[NRM*AW +: AW];
                if (EN_M && defect[NRP] && roots[NRP*AW +: AW] < best) best = roots[NRP*AW +: AW];
            end
        end

        assign next_roots[p*AW +: AW] = best;
    end

    assign changed = (next_roots != roots);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            defect <= '0;
            roots  <= '0;
        end else if (new_round_start) begin
            defect <= measurements;
            roots  <= own_roots;
        end else if (step) begin
            roots <= next_roots;
        end
    end

endmodule

// File: rtl/syndrome_layer_buffer.sv
// Assembles one syndrome from per-round layers; refills while the previous
// syndrome is being decoded and empties when the top takes the whole syndrome.
module syndrome_layer_buffer
    import helios_stream_pkg::*;
#(
    parameter int LAYER_PUS          = 6,
    parameter int MEASUREMENT_ROUNDS = 3,
    localparam int PU_COUNT          = LAYER_PUS * MEASUREMENT_ROUNDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_layer_valid,
    output logic                 s_layer_ready,
    input  logic [LAYER_PUS-1:0] s_layer_data,
    input  logic                 transfer,
    output logic                 full,
    output logic [PU_COUNT-1:0]  flat
);

    localparam int LCW = $clog2(MEASUREMENT_ROUNDS + 1);
    localparam logic [LCW-1:0] LC_FULL = LCW'(MEASUREMENT_ROUNDS);

    logic [LCW-1:0] lc;

    assign full          = (lc == LC_FULL);
    assign s_layer_ready = !full;

    // Handshake and transfer never coincide: ready is low whenever the buffer is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lc   <= '0;
            flat <= '0;
        end else if (transfer) begin
            lc   <= '0;
            flat <= '0;
        end else if (s_layer_valid && s_layer_ready) begin
            flat[lc*LAYER_PUS +: LAYER_PUS] <= s_layer_data;
            lc <= lc + LCW'(1);
        end
    end

endmodule

// File: rtl/unified_controller.sv
// Sequences graph steps after a round start and reports convergence together
// with the iteration and cycle counts of the current decode.
module unified_controller
    import helios_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        new_round_start,
    input  logic        changed,
    output logic        step,
    output logic        result_valid,
    output logic [7:0]  iteration_counter,
    output logic [31:0] cycle_counter
);

    logic [1:0] stage;

    assign step = (stage == CTRL_RUN);

    // result_valid is a single-cycle pulse on the first step that changes nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage             <= CTRL_IDLE;
            result_valid      <= 1'b0;
            iteration_counter <= '0;
            cycle_counter     <= '0;
        end else begin
            result_valid <= 1'b0;
            if (new_round_start) begin
                stage             <= CTRL_RUN;
                iteration_counter <= '0;
                cycle_counter     <= '0;
            end else if (stage == CTRL_RUN) begin
                cycle_counter <= cycle_counter + 32'd1;
                if (changed) begin
                    if (iteration_counter != 8'hFF)
                        iteration_counter <= iteration_counter + 8'd1;
                end else begin
                    stage        <= CTRL_DONE;
                    result_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/helios_stream_decoder.sv
// Streaming Helios top: layered syndrome input, decode launch with timeout,
// and per-layer root output. Both streams: a beat moves on a clock edge where valid && ready.
module helios_stream_decoder
    import helios_stream_pkg::*;
#(
    parameter int CODE_DISTANCE_X    = 3,
    parameter int CODE_DISTANCE_Z    = 2,
    parameter int MEASUREMENT_ROUNDS = max_of(CODE_DISTANCE_X, CODE_DISTANCE_Z),
    parameter int WEIGHT_X           = 2,
    parameter int WEIGHT_Z           = 2,
    parameter int WEIGHT_M           = 2,
    parameter int MAX_ITERATIONS     = 200,
    localparam int LAYER_PUS         = CODE_DISTANCE_X * CODE_DISTANCE_Z,
    localparam int PU_COUNT          = LAYER_PUS * MEASUREMENT_ROUNDS,
    localparam int ADDRESS_WIDTH     = addr_width(CODE_DISTANCE_X, CODE_DISTANCE_Z, MEASUREMENT_ROUNDS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_layer_valid,
    output logic                               s_layer_ready,
    input  logic [LAYER_PUS-1:0]               s_layer_data,
    output logic                               m_root_valid,
    input  logic                               m_root_ready,
    output logic [ADDRESS_WIDTH*LAYER_PUS-1:0] m_root_data,
    output logic                               m_root_last,
    output logic                               m_root_timeout,
    output logic                               busy,
    output logic [31:0]                        last_cycle_count,
    output logic [15:0]                        decode_count,
    output logic [7:0]                         timeout_count
);

    localparam int LAYER_BITS = ADDRESS_WIDTH * LAYER_PUS;
    localparam int OCW = $clog2(MEASUREMENT_ROUNDS + 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(MEASUREMENT_ROUNDS - 1);
    localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITERATIONS);

    state_t state_q, state_d;
    logic [OCW-1:0] oc_q;
    logic timeout_q;
    logic buffer_full, transfer, new_round_start;
    logic step, changed, result_valid;
    logic capture_done, capture_timeout, last_beat, drain_hs;
    logic [PU_COUNT-1:0] buffer_flat, core_meas;
    logic [7:0] iteration_counter;
    logic [31:0] cycle_counter;
    logic [ADDRESS_WIDTH*PU_COUNT-1:0] core_roots, root_q;

    syndrome_layer_buffer #(
        .LAYER_PUS(LAYER_PUS),
        .MEASUREMENT_ROUNDS(MEASUREMENT_ROUNDS)
    ) u_buffer (
        .clk(clk), .reset(reset),
        .s_layer_valid(s_layer_valid), .s_layer_ready(s_layer_ready), .s_layer_data(s_layer_data),
        .transfer(transfer), .full(buffer_full), .flat(buffer_flat)
    );

    single_FPGA_decoding_graph #(
        .CODE_DISTANCE_X(CODE_DISTANCE_X), .CODE_DISTANCE_Z(CODE_DISTANCE_Z),
        .MEASUREMENT_ROUNDS(MEASUREMENT_ROUNDS),
        .WEIGHT_X(WEIGHT_X), .WEIGHT_Z(WEIGHT_Z), .WEIGHT_M(WEIGHT_M),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_graph (
        .clk(clk), .reset(reset), .new_round_start(new_round_start), .step(step),
        .measurements(core_meas), .changed(changed), .roots(core_roots)
    );

    unified_controller u_ctrl (
        .clk(clk), .reset(reset), .new_round_start(new_round_start), .changed(changed),
        .step(step), .result_valid(result_valid),
        .iteration_counter(iteration_counter), .cycle_counter(cycle_counter)
    );

    assign last_beat      = (oc_q == OC_LAST);
    assign m_root_valid   = (state_q == ST_DRAIN);
    assign m_root_last    = m_root_valid && last_beat;
    assign m_root_data    = root_q[oc_q*LAYER_BITS +: LAYER_BITS];
    assign m_root_timeout = timeout_q;
    assign busy           = (state_q != ST_IDLE);
    assign drain_hs       = m_root_valid && m_root_ready;

    always_comb begin
        state_d         = state_q;
        transfer        = 1'b0;
        new_round_start = 1'b0;
        capture_done    = 1'b0;
        capture_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buffer_full) begin
                    transfer = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                new_round_start = 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the threshold cycle still counts as a clean decode.
                if (result_valid) begin
                    capture_done = 1'b1;
                    state_d      = ST_DRAIN;
                end else if (iteration_counter >= ITER_LIMIT) begin
                    capture_timeout = 1'b1;
                    state_d         = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_root_ready && last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            oc_q             <= '0;
            timeout_q        <= 1'b0;
            core_meas        <= '0;
            root_q           <= '0;
            last_cycle_count <= '0;
            decode_count     <= '0;
            timeout_count    <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) core_meas <= buffer_flat;
            if (capture_done) begin
                root_q           <= core_roots;
                last_cycle_count <= cycle_counter;
                decode_count     <= decode_count + 16'd1;
            end
            if (capture_timeout) begin
                root_q    <= core_roots;
                timeout_q <= 1'b1;
                if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            end
            if (drain_hs) begin
                if (last_beat) begin
                    oc_q      <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    oc_q <= oc_q + OCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_helios_stream_decoder.sv
// Directed bench for helios_stream_decoder: a default instance plus a second
// instance with a one-iteration limit, selected onto shared stimulus by sel.
module tb_helios_stream_decoder;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    logic s_valid;
    logic [5:0] s_data;
    logic m_ready;

    logic a_sready, a_mvalid, a_last, a_to, a_busy;
    logic [35:0] a_mdata;
    logic [31:0] a_lcc;
    logic [15:0] a_dc;
    logic [7:0] a_tc;
    logic b_sready, b_mvalid, b_last, b_to, b_busy;
    logic [35:0] b_mdata;
    logic [31:0] b_lcc;
    logic [15:0] b_dc;
    logic [7:0] b_tc;

    logic s_ready_obs, m_valid_obs, m_last_obs, m_to_obs, busy_obs;
    logic [35:0] m_data_obs;
    logic [15:0] dc_obs;
    logic [7:0] tc_obs;

    int n_assert = 0;
    int n_fail = 0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    helios_stream_decoder dut_a (
        .clk(clk), .reset(reset),
        .s_layer_valid(s_valid && !sel), .s_layer_ready(a_sready), .s_layer_data(s_data),
        .m_root_valid(a_mvalid), .m_root_ready(m_ready && !sel), .m_root_data(a_mdata),
        .m_root_last(a_last), .m_root_timeout(a_to), .busy(a_busy),
        .last_cycle_count(a_lcc), .decode_count(a_dc), .timeout_count(a_tc)
    );

    helios_stream_decoder #(.MAX_ITERATIONS(1)) dut_b (
        .clk(clk), .reset(reset),
        .s_layer_valid(s_valid && sel), .s_layer_ready(b_sready), .s_layer_data(s_data),
        .m_root_valid(b_mvalid), .m_root_ready(m_ready && sel), .m_root_data(b_mdata),
        .m_root_last(b_last), .m_root_timeout(b_to), .busy(b_busy),
        .last_cycle_count(b_lcc), .decode_count(b_dc), .timeout_count(b_tc)
    );

    assign s_ready_obs = sel ? b_sready : a_sready;
    assign m_valid_obs = sel ? b_mvalid : a_mvalid;
    assign m_last_obs  = sel ? b_last   : a_last;
    assign m_to_obs    = sel ? b_to     : a_to;
    assign busy_obs    = sel ? b_busy   : a_busy;
    assign m_data_obs  = sel ? b_mdata  : a_mdata;
    assign dc_obs      = sel ? b_dc     : a_dc;
    assign tc_obs      = sel ? b_tc     : a_tc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address {round, z, x}, two bits each, for PU i of layer r.
    function automatic logic [35:0] own_layer(input int r);
        logic [35:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v[i*6 +: 6] = 6'((r << 4) | ((i / 3) << 2) | (i % 3));
        return v;
    endfunction

    function automatic logic [35:0] set_root(input logic [35:0] v, input int i, input logic [5:0] root);
        logic [35:0] t;
        t = v;
        t[i*6 +: 6] = root;
        return t;
    endfunction

    task automatic push_syn(input logic [35:0] l0, input logic [35:0] l1, input logic [35:0] l2);
        exp_q.push_back(l0);
        exp_q.push_back(l1);
        exp_q.push_back(l2);
    endtask

    task automatic send_layer(input logic [5:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready_obs !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready_wait", 64'(n < 200), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_syn(input logic [5:0] l0, input logic [5:0] l1, input logic [5:0] l2);
        send_layer(l0);
        send_layer(l1);
        send_layer(l2);
    endtask

    task automatic recv_syndrome(input logic exp_to, input bit rand_rdy);
        int got, n;
        bit stalled;
        logic [35:0] prev_d, e;
        logic prev_l;
        got = 0; n = 0; stalled = 0; prev_d = '0; prev_l = 1'b0;
        while (got < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (stalled) begin
                check("stall_valid", 64'(m_valid_obs), 64'd1);
                check("stall_data", 64'(m_data_obs), 64'(prev_d));
                check("stall_last", 64'(m_last_obs), 64'(prev_l));
            end
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
            if (m_valid_obs === 1'b1) begin
                if (m_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
                    check("root_data", 64'(m_data_obs), 64'(e));
                    check("root_last", 64'(m_last_obs), 64'(got == 2));
                    check("root_timeout", 64'(m_to_obs), 64'(exp_to));
                    got++;
                end else begin
                    stalled = 1;
                    prev_d  = m_data_obs;
                    prev_l  = m_last_obs;
                end
            end
        end
        check("recv_beats", 64'(got), 64'd3);
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready_obs), 64'd1);
        check("rst_m_valid", 64'(m_valid_obs), 64'd0);
        check("rst_m_last", 64'(m_last_obs), 64'd0);
        check("rst_m_timeout", 64'(m_to_obs), 64'd0);
        check("rst_busy", 64'(busy_obs), 64'd0);
        check("rst_m_data", 64'(m_data_obs), 64'd0);
        check("rst_counts", {8'h0, a_lcc, dc_obs, tc_obs}, 64'd0);
        reset = 1'b0;

        // Defect pair at PU 0/1 of layer 0: PU 1 adopts PU 0's root.
        push_syn(set_root(own_layer(0), 1, 6'd0), own_layer(1), own_layer(2));
        send_syn(6'b000011, 6'b000000, 6'b000000);
        @(negedge clk);
        check("launch_ready_low", 64'(s_ready_obs), 64'd0);
        check("launch_busy_low", 64'(busy_obs), 64'd0);
        check("launch_nrs_early", 64'(dut_a.new_round_start), 64'd0);
        @(negedge clk);
        check("launch_nrs", 64'(dut_a.new_round_start), 64'd1);
        check("launch_busy", 64'(busy_obs), 64'd1);
        check("launch_ready_back", 64'(s_ready_obs), 64'd1);
        recv_syndrome(1'b0, 1'b0);
        @(negedge clk);
        check("s1_valid_done", 64'(m_valid_obs), 64'd0);
        check("s1_busy_done", 64'(busy_obs), 64'd0);
        check("s1_decode_count", 64'(dc_obs), 64'd1);
        check("s1_cycle_count_nz", 64'(a_lcc != 32'd0), 64'd1);

        // All-zero syndrome: every root is the PU's own address.
        push_syn(own_layer(0), own_layer(1), own_layer(2));
        send_syn(6'b0, 6'b0, 6'b0);
        recv_syndrome(1'b0, 1'b0);
        @(negedge clk);
        check("s2_decode_count", 64'(dc_obs), 64'd2);
        check("s2_timeout_count", 64'(tc_obs), 64'd0);

        // Back-to-back: pair S1 then a vertical pair (layer0 PU2, layer1 PU2).
        push_syn(set_root(own_layer(0), 1, 6'd0), own_layer(1), own_layer(2));
        push_syn(own_layer(0), set_root(own_layer(1), 2, 6'd2), own_layer(2));
        send_syn(6'b000011, 6'b000000, 6'b000000);
        send_syn(6'b000100, 6'b000100, 6'b000000);
        n = 0;
        while (m_valid_obs !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_valid", 64'(m_valid_obs), 64'd1);
        repeat (20) @(negedge clk);
        check("b2b_hold_valid", 64'(m_valid_obs), 64'd1);
        check("b2b_hold_data", 64'(m_data_obs), 64'(exp_q[0]));
        check("b2b_buffer_full", 64'(s_ready_obs), 64'd0);
        recv_syndrome(1'b0, 1'b0);
        @(negedge clk);
        check("b2b_idle_gap", 64'(busy_obs), 64'd0);
        check("b2b_gap_ready", 64'(s_ready_obs), 64'd0);
        @(negedge clk);
        check("b2b_second_nrs", 64'(dut_a.new_round_start), 64'd1);
        check("b2b_second_ready", 64'(s_ready_obs), 64'd1);
        recv_syndrome(1'b0, 1'b0);
        @(negedge clk);
        check("b2b_decode_count", 64'(dc_obs), 64'd4);

        // Reset while the core is running.
        send_syn(6'b000011, 6'b000000, 6'b000000);
        repeat (3) @(negedge clk);
        check("mid_wait_busy", 64'(busy_obs), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_wait_busy", 64'(busy_obs), 64'd0);
        check("rst_wait_ready", 64'(s_ready_obs), 64'd1);
        check("rst_wait_valid", 64'(m_valid_obs), 64'd0);
        check("rst_wait_dc", 64'(dc_obs), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset with two layers buffered: the partial syndrome must vanish.
        send_layer(6'b111111);
        send_layer(6'b111111);
        check("mid_input_lc", 64'(dut_a.u_buffer.lc), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_input_lc", 64'(dut_a.u_buffer.lc), 64'd0);
        check("rst_input_ready", 64'(s_ready_obs), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fresh syndrome (layer1 PU3/PU4) drained under random backpressure.
        push_syn(own_layer(0), set_root(own_layer(1), 4, 6'd20), own_layer(2));
        send_syn(6'b000000, 6'b011000, 6'b000000);
        recv_syndrome(1'b0, 1'b1);
        @(negedge clk);
        check("bp_decode_count", 64'(dc_obs), 64'd1);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // One-iteration limit: the pair decode times out after its first step.
        sel = 1'b1;
        push_syn(set_root(own_layer(0), 1, 6'd0), own_layer(1), own_layer(2));
        send_syn(6'b000011, 6'b000000, 6'b000000);
        recv_syndrome(1'b1, 1'b0);
        @(negedge clk);
        check("to_timeout_count", 64'(tc_obs), 64'd1);
        check("to_decode_count", 64'(dc_obs), 64'd0);
        check("to_flag_cleared", 64'(m_to_obs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t expected under 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
